// File: rtl/minesweeper_input.sv
`default_nettype none
// ============================================================================
// Module   : minesweeper_input
// Purpose  : Button debounce, board cursor and action/ack handshake with a
//            one-deep event hold buffer and saturating drop counter.
// Revision : 1.0
// ============================================================================
module minesweeper_input #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [5:0] BTN,
    input  logic [7:0] ack,
    output logic [7:0] action,
    output logic [5:0] cursor,
    output logic [7:0] dropCnt
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_WREL = 2'd2
    } state_t;

    logic [5:0] press;

    generate
        for (genvar i = 0; i < 6; i++) begin : g_btn
            logic             sync1_q, sync2_q;
            logic             level_q, level_d;
            logic             press_q;
            logic [CNT_W-1:0] cnt_q, cnt_d;

            always_comb begin
                level_d = level_q;
                cnt_d   = '0;
                if (sync2_q != level_q) begin
                    if (cnt_q == C_CNT_MAX) begin
                        level_d = sync2_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge CLK or posedge RESET) begin
                if (RESET) begin
                    sync1_q <= 1'b0;
                    sync2_q <= 1'b0;
                    level_q <= 1'b0;
                    cnt_q   <= '0;
                    press_q <= 1'b0;
                end else begin
                    sync1_q <= BTN[i];
                    sync2_q <= sync1_q;
                    level_q <= level_d;
                    cnt_q   <= cnt_d;
                    press_q <= level_d & ~level_q;
                end
            end

            assign press[i] = press_q;
        end
    endgenerate

    state_t     state_q, state_d;
    logic [7:0] action_q, action_d;
    logic [5:0] cursor_q, cursor_d;
    logic [7:0] drop_q, drop_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_vld_q, hold_vld_d;

    logic       ack_hi;
    logic       ev_vld;
    logic [7:0] ev_byte;
    logic       ev_taken;
    logic       hold_take;
    logic [1:0] drop_inc;
    logic [8:0] drop_sum;
    logic [1:0] row;
    logic [3:0] col;

    assign ack_hi  = ack[7];
    assign ev_vld  = press[4] | press[5];
    // Open wins a simultaneous open+flag, so the flag bit is set only for flag alone.
    assign ev_byte = {1'b1, ~press[4], cursor_q};
    assign row     = cursor_q[5:4];
    assign col     = cursor_q[3:0];

    logic unused_ack;
    assign unused_ack = ^ack[6:0];

    always_comb begin
        cursor_d = cursor_q;
        if (press[0]) begin
            cursor_d = {row - 2'd1, col};
        end else if (press[1]) begin
            cursor_d = {row + 2'd1, col};
        end else if (press[2]) begin
            cursor_d = {row, col - 4'd1};
        end else if (press[3]) begin
            cursor_d = {row, col + 4'd1};
        end
    end

    always_comb begin
        state_d    = state_q;
        action_d   = action_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        hold_take  = 1'b0;
        ev_taken   = 1'b0;
        drop_inc   = {1'b0, press[4] & press[5]};

        case (state_q)
            ST_IDLE: begin
                if (!ack_hi) begin
                    if (hold_vld_q) begin
                        action_d  = hold_q;
                        hold_take = 1'b1;
                        state_d   = ST_PEND;
                    end else if (ev_vld) begin
                        action_d = ev_byte;
                        ev_taken = 1'b1;
                        state_d  = ST_PEND;
                    end
                end
            end
            ST_PEND: begin
                if (ack_hi) begin
                    action_d = 8'd0;
                    state_d  = ST_WREL;
                end
            end
            ST_WREL: begin
                if (!ack_hi) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                action_d = 8'd0;
                state_d  = ST_IDLE;
            end
        endcase

        if (hold_take) begin
            hold_vld_d = 1'b0;
        end
        // A slot freed this cycle can accept the new event immediately.
        if (ev_vld && !ev_taken) begin
            if (!hold_vld_q || hold_take) begin
                hold_d     = ev_byte;
                hold_vld_d = 1'b1;
            end else begin
                drop_inc = drop_inc + 2'd1;
            end
        end

        drop_sum = {1'b0, drop_q} + {7'd0, drop_inc};
        drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            action_q   <= 8'd0;
            cursor_q   <= 6'd0;
            drop_q     <= 8'd0;
            hold_q     <= 8'd0;
            hold_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            action_q   <= action_d;
            cursor_q   <= cursor_d;
            drop_q     <= drop_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
        end
    end

    assign action  = action_q;
    assign cursor  = cursor_q;
    assign dropCnt = drop_q;

endmodule
`default_nettype wire

// File: doc/minesweeper_input.md
# minesweeper_input

Front-panel input stage for the minesweeper board. It debounces six push-buttons and keeps a cursor on the 4×16 board (cells 0–63). Open and flag presses become action bytes, which are handed to the memory-mapped action/ack port pair (action at 246, ack at 247) with a four-phase handshake. One event is buffered while a handshake is in flight; further overflow is counted.

## Interface
- `DEBOUNCE_CYCLES`, default 250000: number of consecutive stable synchronized samples required before a button level is accepted.
- `CNT_W`, default 18: width of each debounce counter. It must hold `DEBOUNCE_CYCLES`.

Ports:
- `CLK  in  1`: system clock. Every register updates on the rising edge.
- `RESET  in  1`: asynchronous, active-high reset.
- `BTN  in  6`: raw, asynchronous, active-high buttons. Bit 0 up, 1 down, 2 left, 3 right, 4 open, 5 flag.
- `ack  in  8`: the ack IO register written by the CPU. Only `ack[7]` is used.
- `action  out  8`: action byte, registered. `[7]` valid, `[6]` 1 = flag / 0 = open, `[5:0]` cell index.
- `cursor  out  6`: current cell index, `row*16 + col`, registered.
- `dropCnt  out  8`: saturating count of discarded events, registered.

## Operation
- **Reset.** `action`=0, `cursor`=0, `dropCnt`=0. Sync flops, debounced levels and counters are 0. The hold buffer is empty. FSM is in IDLE.
- **Synchronizer.** Each `BTN` bit passes through its own 2-flop synchronizer.
- **Debounce counter.** If the synchronized bit equals the debounced level, the counter is cleared. Otherwise the counter increments.
- **Debounce accept.** When the counter reaches `DEBOUNCE_CYCLES`-1 while the bit still differs, the debounced level flips and the counter clears.
- **Press pulse.** A 0→1 flip of the debounced level produces a one-cycle press pulse.
- **Cursor moves.**
  - `row = cursor[5:4]`, `col = cursor[3:0]`.
  - up: row-1; down: row+1. Both wrap modulo 4 and leave col unchanged.
  - left: col-1; right: col+1. Both wrap modulo 16 and leave row unchanged.
  - Moves apply on the edge after the pulse and never depend on handshake state.
  - Same-cycle move pulses are applied with priority up > down > left > right. Only one move is applied; the others are ignored.
- **Events.** An open or flag pulse creates the event `{1, isFlag, cursor}`, using the cursor value before any same-cycle move. If open and flag pulse together, open is kept and flag counts as one drop.
- **Handshake FSM.**
  - **IDLE** (`action`=0). If `ack[7]`=0 and an event source exists, load `action` and go to PEND. The source is the hold buffer first, otherwise the new event.
  - **PEND.** `action` is held stable. When `ack[7]`=1, clear `action` to 0 and go to WREL.
  - **WREL.** When `ack[7]`=0, go to IDLE.
- **Hold buffer.**
  - A new event not loaded into `action` goes into the hold buffer if it is empty, or if the buffer is being emptied into `action` that same cycle.
  - Otherwise the event is dropped and `dropCnt` increments, saturating at 255.
  - IDLE with `ack[7]`=1 (stale ack after reset) does not load `action`; events go to the hold buffer.

## Timing
- **Press latency.** `BTN` rises and stays high.
  - The debounced level flips DEBOUNCE_CYCLES+2 edges later.
  - `cursor` or `action` changes on the following edge. Total latency is DEBOUNCE_CYCLES+3 edges.
- **Bounce.** Any glitch shorter than DEBOUNCE_CYCLES samples produces no pulse. Release is debounced identically and produces no event.
- **Ack latency.**
  - `ack[7]` rising in PEND clears `action` on the next edge.
  - `ack[7]` falling in WREL reaches IDLE on the next edge.
  - A buffered event is presented one edge after that, so there are at least 2 edges between successive valid actions.
- **Asynchronous reset mid-handshake** clears `action`, the hold buffer and `dropCnt` immediately. The CPU must rewrite `ack` to 0 before new actions are presented.

## Test plan
- **Cursor wrap.** With DEBOUNCE_CYCLES=4: from reset, 1 left press → `cursor`=15. Then 1 up press → `cursor`=63. Then 1 down and 1 right press → `cursor`=0.
- **Bounce rejection.** Open toggles every 2 cycles for 20 cycles, then holds high. Exactly one event `action`=8'h80 appears DEBOUNCE_CYCLES+3 edges after the hold begins.
- **Handshake.** Move the cursor to 37 and press flag → `action`=8'hE5. Drive `ack`=8'h80 → `action`=0 next edge. Drive `ack`=0 → FSM returns to IDLE.
- **Buffer and overflow.** With `ack` held 0 and PEND at cursor 0, press open, flag, then open. The first event (`action`=8'h80) is held, the flag (8'hC0) is buffered, the last open is dropped → `dropCnt`=1. Completing the handshake presents 8'hC0.
- **Simultaneous press.** Open and flag are debounced on the same cycle at cursor 5 → `action`=8'h85 and `dropCnt` increments by 1.
- **Stale ack.** `ack`=8'h80 at reset release; press open → `action` stays 0. Set `ack`=0 → `action`=8'h80 within 1 edge.
